flicky_sprcoll_ram: RTL and testbench
=====================================

# flicky_sprcoll_ram

Sprite-to-sprite collision capture RAM: sits directly downstream of the sprite line renderer and records every `sprcoll`/`sprcoll_ad` pulse the renderer emits. It holds a 1024 x 1 collision map indexed by {sprite number[4:0], colliding sprite number[4:0]}. The map is readable and clearable by the CPU, and the block also provides a live population count and an "any collision" summary flag. After reset it runs a hardware clear sweep, so the map never holds power-on garbage.

## Interface
Parameters:
- `ADDR_W`, 10, collision map address width (depth = 2**ADDR_W)
- `CNT_W`, 11, population counter width (must hold 2**ADDR_W)

Ports:
- `VCLKx4`  in  1  sole clock, rising edge; same clock as the sprite renderer
- `RESET`  in  1  synchronous, active-high reset
- `sprcoll`  in  1  one-cycle collision pulse from the sprite renderer
- `sprcoll_ad`  in  ADDR_W  collision map address; valid while `sprcoll`=1
- `cpu_rd`  in  1  read strobe, one cycle
- `cpu_wr`  in  1  write strobe, one cycle; clears the addressed bit (write data is ignored)
- `cpu_ad`  in  ADDR_W  CPU map address
- `cpu_dout`  out  8  {7'b0, bit}; registered
- `busy`  out  1  clear sweep in progress
- `any_coll`  out  1  high when `coll_count` != 0
- `coll_count`  out  CNT_W  number of set bits in the map

## Operation
- State machine: SWEEP and RUN.
- SWEEP
  - Entered while `RESET`=1; the sweep address resets to 0.
  - Each cycle after `RESET` falls, one map bit at the sweep address is cleared, then the address increments.
  - After address 2**ADDR_W-1 is cleared, the next state is RUN.
  - `sprcoll` and `cpu_wr` are ignored; `cpu_rd` loads `cpu_dout`=0.
- RUN
  - `sprcoll`=1 sets `map[sprcoll_ad]`.
  - `cpu_wr`=1 clears `map[cpu_ad]`.
  - `cpu_rd`=1 loads `cpu_dout` <= {7'b0, map[cpu_ad]}, sampled before any same-cycle update.
- Simultaneous events, same cycle:
  - Set and clear at different addresses: both take effect.
  - Set and clear at the same address: set wins, so the bit ends at 1.
  - Read and write at the same address: read returns the pre-write value.
  - `cpu_rd` and `cpu_wr` together: both are honoured.
- Counter, all arithmetic CNT_W-bit unsigned:
  - inc = `sprcoll` AND old bit at `sprcoll_ad` == 0.
  - dec = `cpu_wr` AND old bit at `cpu_ad` == 1 AND NOT (`sprcoll` AND `sprcoll_ad`==`cpu_ad`).
  - `coll_count` <= `coll_count` + inc - dec.
  - Saturation is never needed; count ≤ 2**ADDR_W by construction.
- `any_coll` is registered from the next-state count, so it tracks `coll_count` in the same cycle.
- `RESET` asserted mid-sweep or mid-RUN: the sweep restarts from 0, the counter goes to 0 and `busy` goes to 1.

## Timing
- Reset values: `cpu_dout`=0, `busy`=1, `any_coll`=0, `coll_count`=0.
- Map bit update visible to `cpu_rd` one cycle after the `sprcoll`/`cpu_wr` cycle.
- `cpu_dout` is valid the cycle after `cpu_rd` and holds until the next `cpu_rd`.
- `coll_count` and `any_coll` change the cycle after the causing event.
- Sweep: `busy`=1 for exactly 2**ADDR_W cycles after `RESET` deasserts; it falls at the start of cycle 2**ADDR_W+1.
- Zero wait states for the CPU; no backpressure to the renderer, which may pulse every cycle.

## Structure
- Shared package `flicky_pkg`:
  - `COLL_ADDR_W`=10, `COLL_DEPTH`=1024.
  - State enum `coll_state_t` {SWEEP, RUN}.
- Sub-module `flicky_coll_bitram`:
  - 1024-bit flop array.
  - Two asynchronous read ports (set address, CPU address).
  - One set port and one clear port, set-priority on address equality.
  - The sweep drives the clear port.
- Top level holds the FSM, sweep counter, CPU read register and population counter.

## Test plan
- Reset release: hold `RESET` 3 cycles, then release → `busy`=1 for 1024 cycles then 0; reading every address returns 0; `coll_count`=0.
- Set and read: pulse `sprcoll` at ad 0x123, then at 0x123 again, then at 0x3FF → `coll_count`=2, `any_coll`=1; `cpu_rd` 0x123 → `cpu_dout`=0x01 next cycle.
- CPU clear: from the previous state, `cpu_wr` 0x123 → `coll_count`=1; `cpu_rd` 0x123 → 0x00; `cpu_wr` 0x123 again → count stays 1.
- Same-cycle collision: `sprcoll` ad 0x055 with `cpu_wr` 0x055 on a clear bit → bit=1, count +1; repeat on the now-set bit → bit=1, count unchanged; `cpu_rd` 0x055 in the same cycle → returns the pre-update value.
- Sweep lockout: pulse `sprcoll` 0x010 and `cpu_wr` during `busy` → ignored; after `busy` falls, map is all zero and `coll_count`=0.
- Mid-operation reset: set 5 bits, assert `RESET` 1 cycle during RUN → `coll_count`=0 and `busy`=1 immediately; after 1024 cycles, all 5 bits read 0.

Source files
------------

// File: rtl/flicky_pkg.sv
// Shared definitions for the flicky sprite collision capture logic.
package flicky_pkg;

  localparam int COLL_ADDR_W = 10;
  localparam int COLL_DEPTH  = 1 << COLL_ADDR_W;

  typedef enum logic {
    SWEEP,
    RUN
  } coll_state_t;

endpackage

// File: rtl/flicky_coll_bitram.sv
// Single-bit collision map: flop array with two async read ports, one set port and one clear port.
module flicky_coll_bitram #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_ad,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_ad,
  input  logic [ADDR_W-1:0] rd_ad,
  output logic              set_bit,
  output logic              rd_bit
);

  logic [(1 << ADDR_W)-1:0] map;

  assign set_bit = map[set_ad];
  assign rd_bit  = map[rd_ad];

  // Set is written last so it wins when both ports hit the same bit.
  always_ff @(posedge clk) begin
    if (clr_en) map[clr_ad] <= 1'b0;
    if (set_en) map[set_ad] <= 1'b1;
  end

endmodule

// File: rtl/flicky_sprcoll_ram.sv
// Sprite collision capture RAM: post-reset clear sweep, CPU read/clear, live population count.
module flicky_sprcoll_ram
  import flicky_pkg::*;
#(
  parameter int ADDR_W = COLL_ADDR_W,
  parameter int CNT_W  = 11
) (
  input  logic              VCLKx4,
  input  logic              RESET,
  input  logic              sprcoll,
  input  logic [ADDR_W-1:0] sprcoll_ad,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_ad,
  output logic [7:0]        cpu_dout,
  output logic              busy,
  output logic              any_coll,
  output logic [CNT_W-1:0]  coll_count
);

  coll_state_t       state, state_next;
  logic [ADDR_W-1:0] sweep_ad;
  logic              run;
  logic              set_en, clr_en;
  logic [ADDR_W-1:0] clr_ad;
  logic              set_bit, rd_bit;
  logic              inc, dec;
  logic [CNT_W-1:0]  count_next;

  assign run  = (state == RUN);
  assign busy = (state == SWEEP);

  assign set_en = !RESET && run && sprcoll;
  assign clr_en = !RESET && (busy || (run && cpu_wr));
  assign clr_ad = run ? cpu_ad : sweep_ad;

  flicky_coll_bitram #(.ADDR_W(ADDR_W)) u_bitram (
    .clk     (VCLKx4),
    .set_en  (set_en),
    .set_ad  (sprcoll_ad),
    .clr_en  (clr_en),
    .clr_ad  (clr_ad),
    .rd_ad   (cpu_ad),
    .set_bit (set_bit),
    .rd_bit  (rd_bit)
  );

  // A clear that collides with a same-address set loses, so it must not decrement.
  assign inc = set_en && !set_bit;
  assign dec = !RESET && run && cpu_wr && rd_bit && !(sprcoll && (sprcoll_ad == cpu_ad));

  always_comb begin
    count_next = coll_count + CNT_W'(inc) - CNT_W'(dec);
    if (RESET) count_next = '0;
  end

  always_comb begin
    state_next = state;
    if (RESET)
      state_next = SWEEP;
    else if (state == SWEEP && sweep_ad == '1)
      state_next = RUN;
  end

  always_ff @(posedge VCLKx4) begin
    state      <= state_next;
    coll_count <= count_next;
    any_coll   <= (count_next != '0);
    if (RESET) begin
      sweep_ad <= '0;
      cpu_dout <= '0;
    end else begin
      if (busy) sweep_ad <= sweep_ad + 1'b1;
      if (cpu_rd) cpu_dout <= {7'b0, run & rd_bit};
    end
  end

endmodule

// File: tb/tb_flicky_sprcoll_ram.sv
// Self-checking bench for flicky_sprcoll_ram: directed table, corner sequences, random vs. set-based model.
module tb_flicky_sprcoll_ram;

  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic          VCLKx4 = 1'b0;
  logic          RESET = 1'b1;
  logic          sprcoll = 1'b0;
  logic [AW-1:0] sprcoll_ad = '0;
  logic          cpu_rd = 1'b0;
  logic          cpu_wr = 1'b0;
  logic [AW-1:0] cpu_ad = '0;
  logic [7:0]    cpu_dout;
  logic          busy;
  logic          any_coll;
  logic [10:0]   coll_count;

  flicky_sprcoll_ram #(.ADDR_W(AW), .CNT_W(11)) dut (
    .VCLKx4     (VCLKx4),
    .RESET      (RESET),
    .sprcoll    (sprcoll),
    .sprcoll_ad (sprcoll_ad),
    .cpu_rd     (cpu_rd),
    .cpu_wr     (cpu_wr),
    .cpu_ad     (cpu_ad),
    .cpu_dout   (cpu_dout),
    .busy       (busy),
    .any_coll   (any_coll),
    .coll_count (coll_count)
  );

  always #5 VCLKx4 = ~VCLKx4;

  int checks = 0;
  int errors = 0;

  // Reference model: the map as a plain bit array; the count is its population.
  bit       m_map [DEPTH];
  int       sweep_left = DEPTH;
  bit [7:0] m_dout = '0;

  typedef struct {
    bit          sc;
    bit [AW-1:0] sad;
    bit          wr;
    bit          rd;
    bit [AW-1:0] cad;
    bit [7:0]    dout;
    int          cnt;
  } vec_t;

  vec_t vecs[13];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int popcount();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) n += m_map[i];
    return n;
  endfunction

  task automatic idle_inputs();
    sprcoll = 1'b0;
    cpu_wr  = 1'b0;
    cpu_rd  = 1'b0;
  endtask

  // Advance the model with the current inputs, clock once, compare all outputs.
  task automatic cycle();
    int pop;
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) m_map[i] = 1'b0;
      sweep_left = DEPTH;
      m_dout = '0;
    end else if (sweep_left > 0) begin
      sweep_left--;
      if (cpu_rd) m_dout = '0;
    end else begin
      if (cpu_rd) m_dout = {7'b0, m_map[cpu_ad]};
      if (cpu_wr) m_map[cpu_ad] = 1'b0;
      if (sprcoll) m_map[sprcoll_ad] = 1'b1;
    end
    @(posedge VCLKx4);
    #1;
    pop = popcount();
    check("busy", busy, sweep_left > 0);
    check("coll_count", coll_count, pop);
    check("any_coll", any_coll, pop != 0);
    check("cpu_dout", cpu_dout, m_dout);
  endtask

  task automatic wait_sweep(output int n);
    n = 0;
    while (busy && n < DEPTH + 100) begin
      cycle();
      n++;
    end
  endtask

  task automatic read_at(input logic [AW-1:0] a);
    idle_inputs();
    cpu_rd = 1'b1;
    cpu_ad = a;
    cycle();
    cpu_rd = 1'b0;
  endtask

  task automatic set_at(input logic [AW-1:0] a);
    idle_inputs();
    sprcoll    = 1'b1;
    sprcoll_ad = a;
    cycle();
    sprcoll = 1'b0;
  endtask

  initial begin
    int n;
    logic [AW-1:0] five [5];

    vecs[0]  = '{1'b1, 10'h123, 1'b0, 1'b0, 10'h000, 8'h00, 1};
    vecs[1]  = '{1'b1, 10'h123, 1'b0, 1'b0, 10'h000, 8'h00, 1};
    vecs[2]  = '{1'b1, 10'h3FF, 1'b0, 1'b0, 10'h000, 8'h00, 2};
    vecs[3]  = '{1'b0, 10'h000, 1'b0, 1'b1, 10'h123, 8'h01, 2};
    vecs[4]  = '{1'b0, 10'h000, 1'b1, 1'b0, 10'h123, 8'h01, 1};
    vecs[5]  = '{1'b0, 10'h000, 1'b0, 1'b1, 10'h123, 8'h00, 1};
    vecs[6]  = '{1'b0, 10'h000, 1'b1, 1'b0, 10'h123, 8'h00, 1};
    vecs[7]  = '{1'b1, 10'h055, 1'b1, 1'b1, 10'h055, 8'h00, 2};
    vecs[8]  = '{1'b1, 10'h055, 1'b1, 1'b1, 10'h055, 8'h01, 2};
    vecs[9]  = '{1'b0, 10'h000, 1'b0, 1'b1, 10'h055, 8'h01, 2};
    vecs[10] = '{1'b1, 10'h010, 1'b1, 1'b0, 10'h3FF, 8'h01, 2};
    vecs[11] = '{1'b0, 10'h000, 1'b0, 1'b1, 10'h3FF, 8'h00, 2};
    vecs[12] = '{1'b0, 10'h000, 1'b1, 1'b1, 10'h010, 8'h01, 1};

    // Power-up reset, then measure the sweep length and read back the whole map.
    RESET = 1'b1;
    repeat (3) cycle();
    check("reset_dout", cpu_dout, 0);
    check("reset_busy", busy, 1);
    check("reset_count", coll_count, 0);
    check("reset_any", any_coll, 0);
    RESET = 1'b0;
    wait_sweep(n);
    check("sweep_len", n, DEPTH);
    for (int a = 0; a < DEPTH; a++) read_at(AW'(a));
    check("post_sweep_count", coll_count, 0);

    // Directed vectors
    foreach (vecs[i]) begin
      sprcoll    = vecs[i].sc;
      sprcoll_ad = vecs[i].sad;
      cpu_wr     = vecs[i].wr;
      cpu_rd     = vecs[i].rd;
      cpu_ad     = vecs[i].cad;
      cycle();
      check($sformatf("vec%0d_dout", i), cpu_dout, vecs[i].dout);
      check($sformatf("vec%0d_count", i), coll_count, vecs[i].cnt);
    end
    idle_inputs();

    // Random traffic, addresses mostly in a small window to force collisions.
    for (int k = 0; k < 3000; k++) begin
      sprcoll    = $urandom_range(0, 1) == 1;
      sprcoll_ad = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 47));
      cpu_wr     = $urandom_range(0, 2) == 0;
      cpu_rd     = $urandom_range(0, 1) == 1;
      cpu_ad     = ($urandom_range(0, 3) == 0) ? sprcoll_ad : AW'($urandom_range(0, 47));
      cycle();
    end
    idle_inputs();

    // Sweep lockout: traffic during busy must be ignored.
    RESET = 1'b1;
    repeat (3) cycle();
    RESET = 1'b0;
    cycle();
    sprcoll = 1'b1; sprcoll_ad = 10'h010;
    cpu_wr = 1'b1; cpu_rd = 1'b1; cpu_ad = 10'h010;
    cycle();
    check("lockout_dout", cpu_dout, 0);
    check("lockout_count", coll_count, 0);
    idle_inputs();
    wait_sweep(n);
    check("lockout_sweep_len", n, DEPTH - 2);
    read_at(10'h010);
    check("lockout_read", cpu_dout, 0);
    check("lockout_final_count", coll_count, 0);

    // Mid-operation reset clears count immediately and the map after a full sweep.
    five = '{10'h001, 10'h0AA, 10'h155, 10'h200, 10'h3FE};
    foreach (five[i]) set_at(five[i]);
    check("five_count", coll_count, 5);
    read_at(10'h0AA);
    check("five_read", cpu_dout, 1);
    RESET = 1'b1;
    cycle();
    RESET = 1'b0;
    check("midreset_count", coll_count, 0);
    check("midreset_busy", busy, 1);
    check("midreset_any", any_coll, 0);
    wait_sweep(n);
    check("midreset_sweep_len", n, DEPTH);
    foreach (five[i]) begin
      read_at(five[i]);
      check($sformatf("midreset_read%0d", i), cpu_dout, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
